latched_word_reader: RTL and testbench

//   Read-side companion to the 32-bit gated D latch bank. Watches the latch gate, detects each

---
 rtl/latched_word_reader.sv | 78 +++++++
 tb/tb_latched_word_reader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/latched_word_reader.sv
// latched_word_reader: snapshots a latch-held word on each gate close into a FIFO with valid/ready output
// Ports:
//   i_clock        system clock, rising edge
//   i_resetn       asynchronous active-low reset
//   i_latch_en     upstream latch gate, synchronous to i_clock
//   i_latch_q      upstream latch q output
//   o_out_data     head-of-FIFO word
//   o_out_valid    FIFO non-empty
//   i_out_ready    consumer accepts o_out_data this cycle
//   o_level        occupancy 0..DEPTH
//   o_overflow     sticky flag: a close was dropped because the FIFO was full
//   i_overflow_clr synchronous clear of o_overflow
//   o_capture_cnt  accepted captures, wraps modulo 2^CNT_W
module latched_word_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     i_clock,
  input  logic                     i_resetn,
  input  logic                     i_latch_en,
  input  logic [WIDTH-1:0]         i_latch_q,
  output logic [WIDTH-1:0]         o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr,
  output logic [CNT_W-1:0]         o_capture_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic             r_en_d;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_close;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept the close
  always_comb begin
    w_close = r_en_d & ~i_latch_en;
    w_full  = r_level == DEPTH[AW:0];
    w_pop   = (r_level != '0) & i_out_ready;
    w_push  = w_close & (~w_full | w_pop);
    w_drop  = w_close & w_full & ~w_pop;
  end
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_en_d     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      r_en_d <= i_latch_en;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_latch_q;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_cnt           <= r_cnt + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level    <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      r_overflow <= w_drop | (r_overflow & ~i_overflow_clr);
    end
  end
  assign o_out_data    = r_mem[r_rd_ptr];
  assign o_out_valid   = r_level != '0;
  assign o_level       = r_level;
  assign o_overflow    = r_overflow;
  assign o_capture_cnt = r_cnt;
endmodule

// File: tb/tb_latched_word_reader.sv
// tb_latched_word_reader: queue-model and directed checks for latched_word_reader
module tb_latched_word_reader;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] q = '0;
  logic        rdy = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic [2:0]  level;
  logic        ovf;
  logic [3:0]  cnt;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mq[$];
  bit          m_en_d = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;
  latched_word_reader #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clock(clk), .i_resetn(rstn), .i_latch_en(en), .i_latch_q(q),
    .o_out_data(data), .o_out_valid(valid), .i_out_ready(rdy),
    .o_level(level), .o_overflow(ovf), .i_overflow_clr(clr), .o_capture_cnt(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_step();
    bit close;
    bit drop;
    if (!rstn) begin
      mq.delete();
      m_en_d = 0;
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      close = m_en_d && !en;
      drop = 0;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (close) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(q);
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_en_d = en;
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end
  always @(negedge clk) begin
    chk("valid", {31'b0, valid}, {31'b0, mq.size() > 0});
    chk("level", {29'b0, level}, mq.size());
    chk("overflow", {31'b0, ovf}, {31'b0, m_ovf});
    chk("capture_cnt", {28'b0, cnt}, m_cnt);
    if (mq.size() > 0) chk("out_data", data, mq[0]);
  end
  task automatic tick(input logic e, input logic [31:0] d, input logic r, input logic c);
    en = e;
    q = d;
    rdy = r;
    clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic capture(input logic [31:0] d);
    tick(1, d, 0, 0);
    tick(0, d, 0, 0);
  endtask
  task automatic drain();
    while (mq.size() > 0) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
  endtask
  initial begin
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_level", {29'b0, level}, 0);
    chk("rst_cnt", {28'b0, cnt}, 0);
    chk("rst_data", data, 0);
    rstn = 1'b1;
    tick(0, 0, 0, 0);
    capture(32'hDEADBEEF);
    chk("t1_valid", {31'b0, valid}, 1);
    chk("t1_data", data, 32'hDEADBEEF);
    chk("t1_level", {29'b0, level}, 1);
    chk("t1_cnt", {28'b0, cnt}, 1);
    drain();
    for (int i = 0; i < 4; i++) capture(32'hA0A0_0000 + i);
    chk("t2_full", {29'b0, level}, 4);
    capture(32'hA0A0_0004);
    chk("t2_ovf", {31'b0, ovf}, 1);
    chk("t2_level", {29'b0, level}, 4);
    chk("t2_cnt", {28'b0, cnt}, 5);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", data, 32'hA0A0_0000 + i);
      tick(0, 0, 1, 0);
    end
    chk("t2_empty", {31'b0, valid}, 0);
    tick(0, 0, 0, 1);
    chk("t3_clr", {31'b0, ovf}, 0);
    for (int i = 0; i < 4; i++) capture(32'hB0B0_0000 + i);
    tick(1, 32'hB0B0_0004, 0, 0);
    tick(0, 32'hB0B0_0004, 1, 0);
    chk("t3_level", {29'b0, level}, 4);
    chk("t3_ovf", {31'b0, ovf}, 0);
    for (int i = 1; i < 5; i++) begin
      chk("t3_order", data, 32'hB0B0_0000 + i);
      tick(0, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) tick(1, 32'h5500_0000 + i, 0, 0);
    tick(0, 32'h12345678, 0, 0);
    chk("t4_level", {29'b0, level}, 1);
    chk("t4_data", data, 32'h12345678);
    tick(1, 32'hC0, 0, 0);
    tick(0, 32'hC0, 0, 0);
    tick(1, 32'hC1, 0, 0);
    tick(0, 32'hC1, 0, 0);
    chk("t4_toggle_level", {29'b0, level}, 3);
    drain();
    capture(32'hD0);
    capture(32'hD1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_valid", {31'b0, valid}, 0);
    chk("t5_level", {29'b0, level}, 0);
    chk("t5_cnt", {28'b0, cnt}, 0);
    tick(1, 32'hEE, 0, 0);
    rstn = 1'b1;
    tick(1, 32'hEE, 0, 0);
    tick(1, 32'hEE, 0, 0);
    chk("t5_nopush", {29'b0, level}, 0);
    tick(0, 32'hEE, 0, 0);
    chk("t5_close", {29'b0, level}, 1);
    drain();
    for (int i = 0; i < 5; i++) capture(32'hE0E0_0000 + i);
    chk("t6_ovf", {31'b0, ovf}, 1);
    tick(1, 32'hE5, 0, 0);
    tick(0, 32'hE5, 0, 1);
    chk("t6_setwins", {31'b0, ovf}, 1);
    tick(0, 0, 0, 1);
    chk("t6_clr", {31'b0, ovf}, 0);
    chk("t6_cnt", {28'b0, cnt}, 5);
    drain();
    for (int i = 0; i < 12; i++) begin
      tick(1, i, 1, 0);
      tick(0, i, 1, 0);
    end
    drain();
    chk("wrap_cnt", {28'b0, cnt}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
